// File: rtl/wb_trace_buffer_pkg.sv
// Shared types and defaults for the writeback trace buffer.
package wb_trace_pkg;

  localparam int SEQ_W  = 16;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;

  typedef struct packed {
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } wb_trace_entry_t;

  function automatic logic is_cand(
    input logic       valid,
    input logic [4:0] rd,
    input logic       filt
  );
    return valid && !(filt && (rd == 5'd0));
  endfunction

endpackage

// File: rtl/wb_trace_buffer_if.sv
// Writeback capture and trace drain signal bundle.
interface wb_trace_buffer_if #(
  parameter int SEQ_W  = 16,
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       WB_Data;
  logic              clear;
  logic              trace_valid;
  logic              trace_ready;
  logic [4:0]        trace_rd;
  logic [31:0]       trace_data;
  logic [SEQ_W-1:0]  trace_seq;
  logic [LW-1:0]     level;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;

  modport master (
    output wb_valid, wb_rd, WB_Data,
    output clear, trace_ready,
    input  trace_valid, trace_rd,
    input  trace_data, trace_seq,
    input  level, overflow, drop_cnt
  );

  modport slave (
    input  wb_valid, wb_rd, WB_Data,
    input  clear, trace_ready,
    output trace_valid, trace_rd,
    output trace_data, trace_seq,
    output level, overflow, drop_cnt
  );

endinterface

// File: rtl/wb_trace_buffer_fifo.sv
// Synchronous first-word-fall-through FIFO.
module wb_trace_fifo #(
  parameter int  DEPTH = 8,
  parameter type T     = logic [7:0],
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  T              din,
  output T              dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  T              mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [LW-1:0] lvl_q;
  logic          do_push, do_pop;

  assign empty = (lvl_q == '0);
  assign full  = (lvl_q == LW'(DEPTH));
  assign level = lvl_q;
  assign dout  = empty ? T'('0) : mem_q[rd_q];

  assign do_pop  = pop && !empty;
  // Full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push && !clear
                && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else if (clear) begin
      rd_q  <= '0;
      wr_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_pop)
        rd_q <= rd_q + AW'(1);
      if (do_push)
        wr_q <= wr_q + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   lvl_q <= lvl_q + LW'(1);
        2'b01:   lvl_q <= lvl_q - LW'(1);
        default: lvl_q <= lvl_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset)
      mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: filter, sequence tag, overflow
// accounting and FWFT drain to a trace sink.
module wb_trace_buffer
  import wb_trace_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int SEQ_W     = 16,
  parameter int DROP_W    = 8,
  parameter bit FILTER_X0 = 1'b1
) (
  input logic         clk,
  input logic         reset,
  wb_trace_buffer_if.slave bus
);

  typedef struct packed {
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [SEQ_W-1:0] seq;
  } entry_t;

  entry_t            wr_e, hd_e;
  logic              full, empty;
  logic              cand, pop, acc, drop;
  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic              ovf_q, ovf_d;
  logic [DROP_W-1:0] drop_q, drop_d;

  assign cand = is_cand(bus.wb_valid,
                        bus.wb_rd, FILTER_X0);
  assign pop  = !empty && bus.trace_ready;
  assign acc  = cand && (!full || pop);
  assign drop = cand && full && !pop;

  assign wr_e = '{rd:   bus.wb_rd,
                  data: bus.WB_Data,
                  seq:  seq_q};

  wb_trace_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clear (bus.clear),
    .push  (cand),
    .pop   (pop),
    .din   (wr_e),
    .dout  (hd_e),
    .full  (full),
    .empty (empty),
    .level (bus.level)
  );

  always_comb begin
    seq_d  = seq_q;
    ovf_d  = ovf_q;
    drop_d = drop_q;
    if (bus.clear) begin
      // Sequence keeps counting across a flush so the sink sees the gap.
      ovf_d  = 1'b0;
      drop_d = '0;
    end else begin
      if (acc)
        seq_d = seq_q + SEQ_W'(1);
      if (drop) begin
        ovf_d = 1'b1;
        if (drop_q != '1)
          drop_d = drop_q + DROP_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seq_q  <= '0;
      ovf_q  <= 1'b0;
      drop_q <= '0;
    end else begin
      seq_q  <= seq_d;
      ovf_q  <= ovf_d;
      drop_q <= drop_d;
    end
  end

  assign bus.trace_valid = !empty;
  assign bus.trace_rd    = hd_e.rd;
  assign bus.trace_data  = hd_e.data;
  assign bus.trace_seq   = hd_e.seq;
  assign bus.overflow    = ovf_q;
  assign bus.drop_cnt    = drop_q;

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Bench for wb_trace_buffer: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_wb_trace_buffer;

  localparam int D = 8;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    int unsigned seq;
  } ment_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  ment_t       m_q[$];
  int unsigned m_seq;
  bit          m_ovf;
  int unsigned m_drop;

  wb_trace_buffer_if #(.SEQ_W(16), .DEPTH(D), .DROP_W(8)) b16 ();
  wb_trace_buffer_if #(.SEQ_W(4),  .DEPTH(D), .DROP_W(8)) b4 ();

  wb_trace_buffer #(.DEPTH(D), .SEQ_W(16), .DROP_W(8), .FILTER_X0(1'b1))
    u_dut (.clk(clk), .reset(reset), .bus(b16));
  wb_trace_buffer #(.DEPTH(D), .SEQ_W(4), .DROP_W(8), .FILTER_X0(1'b1))
    u_dut4 (.clk(clk), .reset(reset), .bus(b4));

  always #5 clk = ~clk;

  // Drive both DUTs identically, clock once, advance the model.
  task automatic cycle(input bit rst, input bit v,
                       input logic [4:0] rd, input logic [31:0] d,
                       input bit rdy, input bit clr);
    bit pop;
    reset          = rst;
    b16.wb_valid   = v;    b4.wb_valid   = v;
    b16.wb_rd      = rd;   b4.wb_rd      = rd;
    b16.WB_Data    = d;    b4.WB_Data    = d;
    b16.trace_ready = rdy; b4.trace_ready = rdy;
    b16.clear      = clr;  b4.clear      = clr;
    @(posedge clk);
    if (rst) begin
      m_q.delete(); m_seq = 0; m_ovf = 0; m_drop = 0;
    end else if (clr) begin
      m_q.delete(); m_ovf = 0; m_drop = 0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      if (pop) void'(m_q.pop_front());
      if (v && rd != 5'd0) begin
        if (m_q.size() < D) begin
          m_q.push_back('{rd, d, m_seq});
          m_seq = (m_seq + 1) & 32'hFFFF;
        end else begin
          m_ovf = 1;
          if (m_drop != 255) m_drop++;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 5'd0, 32'd0, rdy, 0);
  endtask

  task automatic test_reset;
    cycle(1, 1, 5'd3, 32'h1, 1, 0);
    cycle(1, 0, 5'd0, 32'h0, 0, 0);
    checks++;
    if (b16.level !== 4'd0 || b16.trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_lvl level=%0d valid=%0b want 0 0", b16.level, b16.trace_valid);
    end
    checks++;
    if (b16.trace_rd !== 5'd0 || b16.trace_data !== 32'd0 || b16.trace_seq !== 16'd0) begin
      errors++;
      $display("FAIL reset_head rd=%0d data=%h seq=%0d want zeros",
               b16.trace_rd, b16.trace_data, b16.trace_seq);
    end
    checks++;
    if (b16.overflow !== 1'b0 || b16.drop_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_ovf ovf=%0b drop=%0d want 0 0", b16.overflow, b16.drop_cnt);
    end
  endtask

  task automatic test_single;
    cycle(0, 1, 5'd5, 32'hDEADBEEF, 1, 0);
    checks++;
    if (b16.trace_valid !== 1'b1 || b16.trace_rd !== 5'd5 ||
        b16.trace_data !== 32'hDEADBEEF || b16.trace_seq !== 16'd0) begin
      errors++;
      $display("FAIL single_head v=%0b rd=%0d data=%h seq=%0d want 1 5 deadbeef 0",
               b16.trace_valid, b16.trace_rd, b16.trace_data, b16.trace_seq);
    end
    idle(1);
    checks++;
    if (b16.level !== 4'd0 || b16.trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain level=%0d valid=%0b want 0 0", b16.level, b16.trace_valid);
    end
  endtask

  task automatic test_filter;
    cycle(0, 1, 5'd0, 32'h1234, 0, 0);
    checks++;
    if (b16.level !== 4'd0 || b16.trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL filter_x0 level=%0d valid=%0b want 0 0", b16.level, b16.trace_valid);
    end
    cycle(0, 1, 5'd3, 32'h55, 0, 0);
    checks++;
    if (b16.trace_seq !== 16'd1 || b16.trace_rd !== 5'd3) begin
      errors++;
      $display("FAIL filter_seq seq=%0d rd=%0d want 1 3", b16.trace_seq, b16.trace_rd);
    end
    idle(1);
  endtask

  task automatic test_overflow;
    bit bad;
    cycle(1, 0, 5'd0, 32'd0, 0, 0);
    for (int i = 0; i < D + 3; i++)
      cycle(0, 1, 5'(1 + i), 32'(i), 0, 0);
    checks++;
    if (b16.level !== 4'(D) || b16.overflow !== 1'b1 || b16.drop_cnt !== 8'd3) begin
      errors++;
      $display("FAIL ovf_state level=%0d ovf=%0b drop=%0d want %0d 1 3",
               b16.level, b16.overflow, b16.drop_cnt, D);
    end
    bad = 0;
    for (int i = 0; i < D; i++) begin
      if (b16.trace_valid !== 1'b1 || b16.trace_data !== 32'(i) ||
          b16.trace_seq !== 16'(i) || b16.trace_rd !== 5'(1 + i)) begin
        bad = 1;
        $display("FAIL ovf_drain[%0d] data=%0d seq=%0d want %0d %0d",
                 i, b16.trace_data, b16.trace_seq, i, i);
      end
      idle(1);
    end
    checks++;
    if (bad || b16.trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL ovf_order bad=%0b valid=%0b want 0 0", bad, b16.trace_valid);
    end
  endtask

  task automatic test_full_pushpop;
    cycle(1, 0, 5'd0, 32'd0, 0, 0);
    for (int i = 0; i < D; i++)
      cycle(0, 1, 5'd2, 32'(100 + i), 0, 0);
    cycle(0, 1, 5'd4, 32'hAA55, 1, 0);
    checks++;
    if (b16.level !== 4'(D) || b16.drop_cnt !== 8'd0 || b16.overflow !== 1'b0) begin
      errors++;
      $display("FAIL full_pp level=%0d drop=%0d ovf=%0b want %0d 0 0",
               b16.level, b16.drop_cnt, b16.overflow, D);
    end
    checks++;
    if (b16.trace_data !== 32'd101) begin
      errors++;
      $display("FAIL full_pp_head data=%0d want 101", b16.trace_data);
    end
    for (int i = 0; i < D - 1; i++) idle(1);
    checks++;
    if (b16.level !== 4'd1 || b16.trace_data !== 32'hAA55 || b16.trace_rd !== 5'd4) begin
      errors++;
      $display("FAIL full_pp_last level=%0d data=%h rd=%0d want 1 aa55 4",
               b16.level, b16.trace_data, b16.trace_rd);
    end
    idle(1);
  endtask

  task automatic test_seq_wrap;
    int bad;
    cycle(1, 0, 5'd0, 32'd0, 0, 0);
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(0, 1, 5'd7, 32'(i), 1, 0);
      if (b4.trace_seq !== 4'(i % 16) || b16.trace_seq !== 16'(i) ||
          b4.trace_data !== 32'(i)) begin
        bad++;
        $display("FAIL wrap[%0d] seq4=%0d seq16=%0d want %0d %0d",
                 i, b4.trace_seq, b16.trace_seq, i % 16, i);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL seq_wrap bad=%0d want 0", bad);
    end
    cycle(0, 1, 5'd9, 32'h55, 0, 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      idle(0);
      if (b4.trace_valid !== 1'b1 || b4.trace_seq !== 4'd0 ||
          b4.trace_data !== 32'd16 || b4.trace_rd !== 5'd7 || b4.level !== 4'd2)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_stable bad=%0d want 0", bad);
    end
    idle(1);
    idle(1);
  endtask

  task automatic test_clear;
    cycle(1, 0, 5'd0, 32'd0, 0, 0);
    for (int i = 0; i < D + 2; i++)
      cycle(0, 1, 5'd1, 32'(i), 0, 0);
    for (int i = 0; i < D - 3; i++) idle(1);
    checks++;
    if (b16.level !== 4'd3 || b16.drop_cnt !== 8'd2) begin
      errors++;
      $display("FAIL clr_pre level=%0d drop=%0d want 3 2", b16.level, b16.drop_cnt);
    end
    cycle(0, 1, 5'd9, 32'h99, 1, 1);
    checks++;
    if (b16.level !== 4'd0 || b16.overflow !== 1'b0 ||
        b16.drop_cnt !== 8'd0 || b16.trace_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_post level=%0d ovf=%0b drop=%0d valid=%0b want 0 0 0 0",
               b16.level, b16.overflow, b16.drop_cnt, b16.trace_valid);
    end
    cycle(0, 1, 5'd9, 32'h77, 0, 0);
    checks++;
    if (b16.trace_seq !== 16'(D) || b16.trace_data !== 32'h77) begin
      errors++;
      $display("FAIL clr_seq seq=%0d data=%h want %0d 77", b16.trace_seq, b16.trace_data, D);
    end
    idle(1);
  endtask

  task automatic test_random;
    int          bad;
    int unsigned rdy_pct;
    logic [4:0]  rd;
    logic [31:0] e_rd, e_data, e_seq;
    bad = 0;
    rdy_pct = 50;
    for (int n = 0; n < 600; n++) begin
      if (n % 64 == 0) rdy_pct = $urandom_range(90, 10);
      rd = ($urandom_range(7, 0) == 0) ? 5'd0 : 5'($urandom);
      cycle($urandom_range(199, 0) == 0,
            $urandom_range(99, 0) < 70, rd, $urandom,
            $urandom_range(99, 0) < rdy_pct,
            $urandom_range(59, 0) == 0);
      e_rd = 0; e_data = 0; e_seq = 0;
      if (m_q.size() > 0) begin
        e_rd = 32'(m_q[0].rd); e_data = m_q[0].data; e_seq = m_q[0].seq;
      end
      if (b16.level !== 4'(m_q.size()) ||
          b16.trace_valid !== (m_q.size() > 0) ||
          b16.trace_rd !== e_rd[4:0] || b16.trace_data !== e_data ||
          b16.trace_seq !== e_seq[15:0] || b4.trace_seq !== e_seq[3:0] ||
          b16.overflow !== m_ovf || b16.drop_cnt !== 8'(m_drop) ||
          b4.level !== 4'(m_q.size()) || b4.drop_cnt !== 8'(m_drop)) begin
        bad++;
        if (bad <= 5)
          $display("FAIL rand[%0d] lvl=%0d/%0d data=%h/%h seq=%0d/%0d drop=%0d/%0d",
                   n, b16.level, m_q.size(), b16.trace_data, e_data,
                   b16.trace_seq, e_seq, b16.drop_cnt, m_drop);
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL random bad=%0d want 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    b16.wb_valid = 0; b16.wb_rd = 0; b16.WB_Data = 0;
    b16.trace_ready = 0; b16.clear = 0;
    b4.wb_valid = 0; b4.wb_rd = 0; b4.WB_Data = 0;
    b4.trace_ready = 0; b4.clear = 0;
    test_reset();
    test_single();
    test_filter();
    test_overflow();
    test_full_pushpop();
    test_seq_wrap();
    test_clear();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
